// File: rtl/spi_slave_responder_if.sv
// SPI bus and host-side reply/receive signals of spi_slave_responder.
// The slave modport is the responder; the master modport is the bus master plus host.
interface spi_slave_responder_if #(
   parameter int unsigned CNT_W = 6
);
   logic             sck;
   logic             csn;
   logic             mosi;
   logic             miso;
   logic             miso_oe;
   logic [7:0]       rx_data;
   logic             rx_valid;
   logic [7:0]       tx_data;
   logic             tx_load;
   logic             tx_empty;
   logic             tx_underrun;
   logic [CNT_W-1:0] byte_cnt;
   logic             busy;

   modport slave (
      input  sck, csn, mosi, tx_data, tx_load,
      output miso, miso_oe, rx_data, rx_valid, tx_empty, tx_underrun, byte_cnt, busy
   );

   modport master (
      output sck, csn, mosi, tx_data, tx_load,
      input  miso, miso_oe, rx_data, rx_valid, tx_empty, tx_underrun, byte_cnt, busy
   );
endinterface

// File: rtl/spi_slave_responder.sv
// SPI mode-0 responder: oversamples SCK/CSN/MOSI on clk, strobes received bytes,
// and shifts host-supplied reply bytes (or TX_DEFAULT) out on MISO.
module spi_slave_responder #(
   parameter logic [7:0]  TX_DEFAULT = 8'h0E,
   parameter int unsigned CNT_W      = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_slave_responder_if.slave  bus
);
   typedef enum logic [1:0] {RESYNC, IDLE, ACTIVE} state_t;

   state_t           state_q, state_d;
   logic [2:0]       sck_p, csn_p;
   logic [1:0]       mosi_p;
   logic [1:0]       flush_q;
   logic             sck_rise, sck_fall, csn_rise, csn_fall, csn_s, mosi_s;
   logic             frame_start, frame_end, do_rise, do_fall, load_evt, next_dflt;
   logic [7:0]       next_byte;
   logic [2:0]       bit_cnt;
   logic [7:0]       rx_shift, rx_data_q, tx_shift, tx_buf;
   logic             rx_valid_q, tx_empty_q, tx_underrun_q, dflt_pending, miso_q, miso_oe_q;
   logic [CNT_W-1:0] byte_cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sck_p   <= '0;
         csn_p   <= '1;
         mosi_p  <= '0;
         flush_q <= '0;
         state_q <= RESYNC;
      end else begin
         sck_p   <= {sck_p[1:0], bus.sck};
         csn_p   <= {csn_p[1:0], bus.csn};
         mosi_p  <= {mosi_p[0], bus.mosi};
         flush_q <= {flush_q[0], 1'b1};
         state_q <= state_d;
      end
   end

   assign csn_s    = csn_p[1];
   assign mosi_s   = mosi_p[1];
   assign sck_rise = sck_p[1] & ~sck_p[2];
   assign sck_fall = ~sck_p[1] & sck_p[2];
   assign csn_rise = csn_p[1] & ~csn_p[2];
   assign csn_fall = ~csn_p[1] & csn_p[2];

   // RESYNC holds until the synchronizer has flushed its reset value, so a
   // csn that is already low at reset release is never mistaken for idle-high.
   always_comb begin
      state_d     = state_q;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      do_rise     = 1'b0;
      do_fall     = 1'b0;
      case (state_q)
         RESYNC: if (flush_q[1] && csn_s) state_d = IDLE;
         IDLE: if (csn_fall) begin
            state_d     = ACTIVE;
            frame_start = 1'b1;
         end
         ACTIVE: if (csn_rise) begin
            state_d   = IDLE;
            frame_end = 1'b1;
         end else begin
            do_rise = sck_rise;
            do_fall = sck_fall;
         end
         default: state_d = RESYNC;
      endcase
   end

   assign load_evt  = frame_start | (do_fall & (bit_cnt == 3'd0));
   assign next_dflt = ~bus.tx_load & tx_empty_q;

   always_comb begin
      if (bus.tx_load)      next_byte = bus.tx_data;
      else if (!tx_empty_q) next_byte = tx_buf;
      else                  next_byte = TX_DEFAULT;
   end

   // A default byte loaded at a byte boundary only counts as an underrun once
   // the master clocks its first bit; the trailing load after the last byte never does.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bit_cnt <= '0;  rx_shift <= '0;  rx_data_q <= '0;  rx_valid_q <= 1'b0;
         tx_shift <= '0; tx_buf <= '0;    tx_empty_q <= 1'b1; tx_underrun_q <= 1'b0;
         dflt_pending <= 1'b0; miso_q <= 1'b0; miso_oe_q <= 1'b0; byte_cnt_q <= '0;
      end else begin
         rx_valid_q <= 1'b0;
         if (load_evt) begin
            tx_shift   <= next_byte;
            miso_q     <= next_byte[7];
            tx_empty_q <= 1'b1;
         end else if (bus.tx_load) begin
            tx_buf     <= bus.tx_data;
            tx_empty_q <= 1'b0;
         end
         if (frame_start) begin
            bit_cnt       <= '0;
            byte_cnt_q    <= '0;
            tx_underrun_q <= next_dflt;
            dflt_pending  <= 1'b0;
            miso_oe_q     <= 1'b1;
         end
         if (frame_end) begin
            bit_cnt   <= '0;
            miso_q    <= 1'b0;
            miso_oe_q <= 1'b0;
         end
         if (do_rise) begin
            rx_shift <= {rx_shift[6:0], mosi_s};
            bit_cnt  <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               rx_data_q  <= {rx_shift[6:0], mosi_s};
               rx_valid_q <= 1'b1;
               if (byte_cnt_q != '1) byte_cnt_q <= byte_cnt_q + 1'b1;
            end
            if (bit_cnt == 3'd0 && dflt_pending) begin
               tx_underrun_q <= 1'b1;
               dflt_pending  <= 1'b0;
            end
         end
         if (do_fall) begin
            if (bit_cnt != 3'd0) begin
               tx_shift <= {tx_shift[6:0], 1'b0};
               miso_q   <= tx_shift[6];
            end else begin
               dflt_pending <= next_dflt;
            end
         end
      end
   end

   assign bus.miso        = miso_q;
   assign bus.miso_oe     = miso_oe_q;
   assign bus.rx_data     = rx_data_q;
   assign bus.rx_valid    = rx_valid_q;
   assign bus.tx_empty    = tx_empty_q;
   assign bus.tx_underrun = tx_underrun_q;
   assign bus.byte_cnt    = byte_cnt_q;
   assign bus.busy        = (state_q == ACTIVE);
endmodule

// File: tb/tb_spi_slave_responder.sv
// Directed bench for spi_slave_responder: 5 MHz mode-0 frames driven from clk,
// with hand-computed MISO bytes, rx strobes and status flags.
module tb_spi_slave_responder;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #10 clk = ~clk;

   spi_slave_responder_if #(.CNT_W(6)) bus();

   spi_slave_responder #(.TX_DEFAULT(8'h0E), .CNT_W(6)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int         n_cmp = 0;
   int         n_bad = 0;
   int         since_rise = 0;
   int         vpos_last = -1;
   logic       oe_seen = 1'b0;
   logic [7:0] rx_q[$];

   // Every cycle also records rx_valid strobes and their distance from the last SCK rise drive.
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         since_rise++;
         if (bus.miso_oe) oe_seen = 1'b1;
         if (bus.rx_valid) begin
            rx_q.push_back(bus.rx_data);
            vpos_last = since_rise;
         end
      end
   endtask

   // 5 clk low (MOSI set, MISO sampled at the end), then 5 clk high, per bit.
   task automatic spi_bits(input logic [7:0] b, input int nbits, input int ld_at,
                           input logic [7:0] ld_val, output logic [7:0] got);
      got = '0;
      for (int i = 0; i < nbits; i++) begin
         bus.mosi = b[7-i];
         for (int c = 0; c < 5; c++) begin
            if (i == 0 && c == ld_at) begin
               bus.tx_data = ld_val;
               bus.tx_load = 1'b1;
            end
            cyc(1);
            bus.tx_load = 1'b0;
         end
         got[7-i] = bus.miso;
         bus.sck = 1'b1;
         since_rise = 0;
         cyc(5);
         bus.sck = 1'b0;
      end
   endtask

   task automatic host_load(input logic [7:0] v);
      bus.tx_data = v;
      bus.tx_load = 1'b1;
      cyc(1);
      bus.tx_load = 1'b0;
   endtask

   task automatic test_reset;
      cyc(2);
      rst = 1'b0;
      cyc(4);
      n_cmp++; if (bus.miso !== 1'b0)        begin n_bad++; $display("FAIL rst_miso got %h want 0", bus.miso); end
      n_cmp++; if (bus.miso_oe !== 1'b0)     begin n_bad++; $display("FAIL rst_miso_oe got %h want 0", bus.miso_oe); end
      n_cmp++; if (bus.rx_data !== 8'h00)    begin n_bad++; $display("FAIL rst_rx_data got %h want 00", bus.rx_data); end
      n_cmp++; if (bus.rx_valid !== 1'b0)    begin n_bad++; $display("FAIL rst_rx_valid got %h want 0", bus.rx_valid); end
      n_cmp++; if (bus.tx_empty !== 1'b1)    begin n_bad++; $display("FAIL rst_tx_empty got %h want 1", bus.tx_empty); end
      n_cmp++; if (bus.tx_underrun !== 1'b0) begin n_bad++; $display("FAIL rst_underrun got %h want 0", bus.tx_underrun); end
      n_cmp++; if (bus.byte_cnt !== 6'd0)    begin n_bad++; $display("FAIL rst_byte_cnt got %0d want 0", bus.byte_cnt); end
      n_cmp++; if (bus.busy !== 1'b0)        begin n_bad++; $display("FAIL rst_busy got %h want 0", bus.busy); end
   endtask

   task automatic test_single;
      logic [7:0] got;
      host_load(8'hA5);
      n_cmp++; if (bus.tx_empty !== 1'b0) begin n_bad++; $display("FAIL single_loaded_empty got %h want 0", bus.tx_empty); end
      rx_q.delete();
      bus.csn = 1'b0;
      cyc(3);
      n_cmp++; if (bus.miso_oe !== 1'b1)  begin n_bad++; $display("FAIL single_oe got %h want 1", bus.miso_oe); end
      n_cmp++; if (bus.miso !== 1'b1)     begin n_bad++; $display("FAIL single_first_bit got %h want 1", bus.miso); end
      n_cmp++; if (bus.busy !== 1'b1)     begin n_bad++; $display("FAIL single_busy got %h want 1", bus.busy); end
      n_cmp++; if (bus.tx_empty !== 1'b1) begin n_bad++; $display("FAIL single_consumed got %h want 1", bus.tx_empty); end
      cyc(2);
      spi_bits(8'h3C, 8, -1, 8'h00, got);
      cyc(5);
      n_cmp++; if (got !== 8'hA5)            begin n_bad++; $display("FAIL single_miso got %h want a5", got); end
      n_cmp++; if (rx_q.size() !== 1)        begin n_bad++; $display("FAIL single_strobes got %0d want 1", rx_q.size()); end
      n_cmp++; if (rx_q[0] !== 8'h3C)        begin n_bad++; $display("FAIL single_rx got %h want 3c", rx_q[0]); end
      n_cmp++; if (vpos_last !== 3)          begin n_bad++; $display("FAIL single_latency got %0d want 3", vpos_last); end
      n_cmp++; if (bus.byte_cnt !== 6'd1)    begin n_bad++; $display("FAIL single_byte_cnt got %0d want 1", bus.byte_cnt); end
      n_cmp++; if (bus.tx_underrun !== 1'b0) begin n_bad++; $display("FAIL single_underrun got %h want 0", bus.tx_underrun); end
      bus.csn = 1'b1;
      cyc(5);
      n_cmp++; if (bus.miso_oe !== 1'b0)  begin n_bad++; $display("FAIL single_end_oe got %h want 0", bus.miso_oe); end
      n_cmp++; if (bus.busy !== 1'b0)     begin n_bad++; $display("FAIL single_end_busy got %h want 0", bus.busy); end
      n_cmp++; if (bus.byte_cnt !== 6'd1) begin n_bad++; $display("FAIL single_cnt_hold got %0d want 1", bus.byte_cnt); end
   endtask

   task automatic test_multi;
      logic [7:0] g0, g1, g2;
      host_load(8'h11);
      rx_q.delete();
      bus.csn = 1'b0;
      cyc(5);
      spi_bits(8'h01, 8, 0, 8'h22, g0);
      spi_bits(8'h02, 8, -1, 8'h00, g1);
      spi_bits(8'h03, 8, -1, 8'h00, g2);
      cyc(5);
      n_cmp++; if (g0 !== 8'h11) begin n_bad++; $display("FAIL multi_miso0 got %h want 11", g0); end
      n_cmp++; if (g1 !== 8'h22) begin n_bad++; $display("FAIL multi_miso1 got %h want 22", g1); end
      n_cmp++; if (g2 !== 8'h0E) begin n_bad++; $display("FAIL multi_miso2 got %h want 0e", g2); end
      n_cmp++; if (rx_q.size() !== 3) begin n_bad++; $display("FAIL multi_strobes got %0d want 3", rx_q.size()); end
      n_cmp++; if (rx_q[0] !== 8'h01) begin n_bad++; $display("FAIL multi_rx0 got %h want 01", rx_q[0]); end
      n_cmp++; if (rx_q[1] !== 8'h02) begin n_bad++; $display("FAIL multi_rx1 got %h want 02", rx_q[1]); end
      n_cmp++; if (rx_q[2] !== 8'h03) begin n_bad++; $display("FAIL multi_rx2 got %h want 03", rx_q[2]); end
      n_cmp++; if (bus.tx_underrun !== 1'b1) begin n_bad++; $display("FAIL multi_underrun got %h want 1", bus.tx_underrun); end
      n_cmp++; if (bus.byte_cnt !== 6'd3)    begin n_bad++; $display("FAIL multi_byte_cnt got %0d want 3", bus.byte_cnt); end
      bus.csn = 1'b1;
      cyc(5);
   endtask

   task automatic test_partial;
      logic [7:0] got;
      rx_q.delete();
      bus.csn = 1'b0;
      cyc(5);
      spi_bits(8'hA7, 5, -1, 8'h00, got);
      cyc(5);
      bus.csn = 1'b1;
      cyc(5);
      n_cmp++; if (rx_q.size() !== 0)     begin n_bad++; $display("FAIL partial_no_strobe got %0d want 0", rx_q.size()); end
      n_cmp++; if (bus.byte_cnt !== 6'd0) begin n_bad++; $display("FAIL partial_byte_cnt got %0d want 0", bus.byte_cnt); end
      bus.csn = 1'b0;
      cyc(3);
      n_cmp++; if (bus.tx_underrun !== 1'b1) begin n_bad++; $display("FAIL partial_start_underrun got %h want 1", bus.tx_underrun); end
      cyc(2);
      spi_bits(8'hFF, 8, -1, 8'h00, got);
      cyc(5);
      bus.csn = 1'b1;
      cyc(5);
      n_cmp++; if (got !== 8'h0E)         begin n_bad++; $display("FAIL partial_miso got %h want 0e", got); end
      n_cmp++; if (rx_q.size() !== 1)     begin n_bad++; $display("FAIL partial_next_strobes got %0d want 1", rx_q.size()); end
      n_cmp++; if (rx_q[0] !== 8'hFF)     begin n_bad++; $display("FAIL partial_next_rx got %h want ff", rx_q[0]); end
      n_cmp++; if (bus.byte_cnt !== 6'd1) begin n_bad++; $display("FAIL partial_next_cnt got %0d want 1", bus.byte_cnt); end
   endtask

   task automatic test_reset_mid;
      logic [7:0] got;
      rx_q.delete();
      bus.csn = 1'b0;
      cyc(5);
      spi_bits(8'hF0, 3, -1, 8'h00, got);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
      oe_seen = 1'b0;
      spi_bits(8'hFF, 5, -1, 8'h00, got);
      spi_bits(8'hAA, 8, -1, 8'h00, got);
      cyc(5);
      n_cmp++; if (rx_q.size() !== 0) begin n_bad++; $display("FAIL rmid_no_strobe got %0d want 0", rx_q.size()); end
      n_cmp++; if (oe_seen !== 1'b0)  begin n_bad++; $display("FAIL rmid_oe_seen got %h want 0", oe_seen); end
      n_cmp++; if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL rmid_busy got %h want 0", bus.busy); end
      bus.csn = 1'b1;
      cyc(5);
      host_load(8'hC3);
      bus.csn = 1'b0;
      cyc(5);
      spi_bits(8'h96, 8, -1, 8'h00, got);
      cyc(5);
      bus.csn = 1'b1;
      cyc(5);
      n_cmp++; if (got !== 8'hC3)         begin n_bad++; $display("FAIL rmid_after_miso got %h want c3", got); end
      n_cmp++; if (rx_q[0] !== 8'h96)     begin n_bad++; $display("FAIL rmid_after_rx got %h want 96", rx_q[0]); end
      n_cmp++; if (bus.byte_cnt !== 6'd1) begin n_bad++; $display("FAIL rmid_after_cnt got %0d want 1", bus.byte_cnt); end
   endtask

   task automatic test_bypass;
      logic [7:0] g0, g1;
      host_load(8'h77);
      rx_q.delete();
      bus.csn = 1'b0;
      cyc(5);
      spi_bits(8'h12, 8, -1, 8'h00, g0);
      // ld_at=2 lands tx_load on the clk that registers the byte-boundary fall
      spi_bits(8'h34, 8, 2, 8'h5A, g1);
      cyc(5);
      n_cmp++; if (g0 !== 8'h77)             begin n_bad++; $display("FAIL bypass_miso0 got %h want 77", g0); end
      n_cmp++; if (g1 !== 8'h5A)             begin n_bad++; $display("FAIL bypass_miso1 got %h want 5a", g1); end
      n_cmp++; if (bus.tx_empty !== 1'b1)    begin n_bad++; $display("FAIL bypass_empty got %h want 1", bus.tx_empty); end
      n_cmp++; if (bus.tx_underrun !== 1'b0) begin n_bad++; $display("FAIL bypass_underrun got %h want 0", bus.tx_underrun); end
      n_cmp++; if (rx_q[1] !== 8'h34)        begin n_bad++; $display("FAIL bypass_rx1 got %h want 34", rx_q[1]); end
      bus.csn = 1'b1;
      cyc(5);
   endtask

   initial begin
      bus.sck     = 1'b0;
      bus.csn     = 1'b1;
      bus.mosi    = 1'b0;
      bus.tx_data = 8'h00;
      bus.tx_load = 1'b0;
      test_reset();
      test_single();
      test_multi();
      test_partial();
      test_reset_mid();
      test_bypass();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
